// File: rtl/mips_cpu_lsu.sv
// Load/store unit between the multicycle MIPS MEMORY stage and an Avalon-MM data bus.
// Handles byte/half/word and LWL/LWR accesses, alignment errors and a waitrequest watchdog.
module mips_cpu_lsu #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned ALIGN_CHECK    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_rt_old,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);

  typedef enum logic [1:0] {StIdle, StReq, StRdata, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       rt_q, rt_d;
  logic [31:0]       wdog_q, wdog_d;
  logic              read_q, read_d, write_q, write_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [31:0]       writedata_q, writedata_d;
  logic [3:0]        byteenable_q, byteenable_d;
  logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  // Request decode, only meaningful in StIdle
  logic       is_half, is_word, legal, misaligned;
  logic [1:0] o_in, eff_o;
  logic [3:0] be_in;
  logic [31:0] wd_in;

  always_comb begin
    o_in       = req_addr[1:0];
    is_half    = (req_op == 4'd2) || (req_op == 4'd3) || (req_op == 4'd9);
    is_word    = (req_op == 4'd4) || (req_op == 4'd10);
    legal      = (req_op <= 4'd6) || (req_op == 4'd8) || is_half || is_word;
    misaligned = (is_half && o_in[0]) || (is_word && (o_in != 2'b00));
    // With alignment checking off, the offending low bits are simply dropped
    eff_o      = is_half ? {o_in[1], 1'b0} : (is_word ? 2'b00 : o_in);
    be_in      = 4'b0000;
    wd_in      = 32'h0;
    unique case (req_op)
      4'd0, 4'd1, 4'd8: be_in = 4'b0001 << eff_o;
      4'd2, 4'd3, 4'd9: be_in = eff_o[1] ? 4'b1100 : 4'b0011;
      4'd4, 4'd10:      be_in = 4'b1111;
      4'd5:             be_in = 4'b1111 >> (2'd3 - o_in);
      4'd6:             be_in = 4'b1111 << o_in;
      default:          be_in = 4'b0000;
    endcase
    unique case (req_op)
      4'd8:    wd_in = {4{req_wdata[7:0]}};
      4'd9:    wd_in = {2{req_wdata[15:0]}};
      4'd10:   wd_in = req_wdata;
      default: wd_in = 32'h0;
    endcase
  end

  // Load result formatting from the latched op/offset
  logic [5:0]  sh, sh_l;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_fmt;

  always_comb begin
    sh       = {1'b0, off_q, 3'b000};
    sh_l     = 6'd24 - sh;
    lane_b   = 8'(readdata >> sh);
    lane_h   = off_q[1] ? readdata[31:16] : readdata[15:0];
    load_fmt = readdata;
    unique case (op_q)
      4'd0:    load_fmt = {{24{lane_b[7]}}, lane_b};
      4'd1:    load_fmt = {24'h0, lane_b};
      4'd2:    load_fmt = {{16{lane_h[15]}}, lane_h};
      4'd3:    load_fmt = {16'h0, lane_h};
      4'd5:    load_fmt = (readdata << sh_l) | (rt_q & ~(32'hFFFF_FFFF << sh_l));
      4'd6:    load_fmt = (readdata >> sh) | (rt_q & ~(32'hFFFF_FFFF >> sh));
      default: load_fmt = readdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    off_d        = off_q;
    rt_d         = rt_q;
    wdog_d       = wdog_q;
    read_d       = read_q;
    write_d      = write_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d  = req_op;
          off_d = eff_o;
          rt_d  = req_rt_old;
          if (!legal || ((ALIGN_CHECK != 0) && misaligned)) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            state_d      = StReq;
            wdog_d       = 32'h0;
            read_d       = !req_op[3];
            write_d      = req_op[3];
            address_d    = {req_addr[ADDR_W-1:2], 2'b00};
            byteenable_d = be_in;
            writedata_d  = wd_in;
          end
        end
      end
      StReq: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (write_q) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = 32'h0;
          end else begin
            state_d = StRdata;
          end
        end else begin
          wdog_d = wdog_q + 32'd1;
          if ((TIMEOUT_CYCLES != 0) && (wdog_d == TIMEOUT_CYCLES)) begin
            read_d       = 1'b0;
            write_d      = 1'b0;
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end
        end
      end
      StRdata: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = load_fmt;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      op_q         <= 4'h0;
      off_q        <= 2'b00;
      rt_q         <= 32'h0;
      wdog_q       <= 32'h0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= '0;
      writedata_q  <= 32'h0;
      byteenable_q <= 4'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      off_q        <= off_d;
      rt_q         <= rt_d;
      wdog_q       <= wdog_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign read       = read_q;
  assign write      = write_q;
  assign address    = address_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule
